// File: rtl/memtest_pkg.sv
// Shared types and constants for the memory-test controllers.
package memtest_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One walking-ones pattern per data bit.
    function automatic int unsigned pattern_count(input int unsigned width_data);
        return width_data;
    endfunction

endpackage

// File: rtl/mem_test_data_bus_checker_shifter.sv
// Barrel shifter that produces the walking pattern from a seed value and a bit index.
module mem_test_data_bus_checker_shifter #(
    parameter int unsigned p_WIDTH          = 8,
    parameter int unsigned p_NUMBER_SHIFTER = 3
) (
    input  logic [p_WIDTH-1:0]          i_value,
    input  logic                        i_RL,
    input  logic [p_NUMBER_SHIFTER-1:0] i_shifter,
    output logic [p_WIDTH-1:0]          o_value,
    output logic                        o_zero
);

    // i_RL=1 shifts left, 0 shifts right.
    always_comb begin
        o_value = i_RL ? (i_value << i_shifter) : (i_value >> i_shifter);
        o_zero  = (o_value == '0);
    end

endmodule

// File: rtl/mem_test_data_bus_checker.sv
// Walking-ones data bus test: write a one-hot word, read it back, compare, advance the bit.
module mem_test_data_bus_checker
    import memtest_pkg::*;
#(
    parameter int unsigned p_WIDTH_DATA     = 8,
    parameter int unsigned p_WIDTH_ADDR     = 8,
    parameter int unsigned p_NUMBER_SHIFTER = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [p_WIDTH_ADDR-1:0] i_addr,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [p_WIDTH_ADDR-1:0] o_mem_addr,
    output logic [p_WIDTH_DATA-1:0] o_mem_wdata,
    input  logic                    i_mem_ack,
    input  logic [p_WIDTH_DATA-1:0] i_mem_rdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_fail,
    output logic [p_WIDTH_DATA-1:0] o_fail_pattern,
    output logic [p_WIDTH_DATA-1:0] o_fail_mask
);

    localparam int unsigned NUM_PATTERNS = pattern_count(p_WIDTH_DATA);
    localparam logic [p_NUMBER_SHIFTER-1:0] LAST_IDX = p_NUMBER_SHIFTER'(NUM_PATTERNS - 1);

    state_t                      state, state_d;
    logic [p_NUMBER_SHIFTER-1:0] idx, idx_d;
    logic [p_WIDTH_ADDR-1:0]     addr_d;
    logic [p_WIDTH_DATA-1:0]     rdata_q, rdata_d;
    logic [p_WIDTH_DATA-1:0]     pattern;
    logic [p_WIDTH_DATA-1:0]     fail_pattern_d, fail_mask_d;
    logic                        fail_d, req_d, we_d, busy_d, done_d;
    logic                        unused_zero;

    mem_test_data_bus_checker_shifter #(
        .p_WIDTH          (p_WIDTH_DATA),
        .p_NUMBER_SHIFTER (p_NUMBER_SHIFTER)
    ) u_shifter (
        .i_value   (p_WIDTH_DATA'(1)),
        .i_RL      (1'b1),
        .i_shifter (idx),
        .o_value   (pattern),
        .o_zero    (unused_zero)
    );

    // Pattern is only presented while a test is running.
    assign o_mem_wdata = o_busy ? pattern : '0;

    // Next-state and next-register decode.
    always_comb begin
        state_d        = state;
        idx_d          = idx;
        addr_d         = o_mem_addr;
        rdata_d        = rdata_q;
        fail_d         = o_fail;
        fail_pattern_d = o_fail_pattern;
        fail_mask_d    = o_fail_mask;

        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d        = WRITE;
                    addr_d         = i_addr;
                    idx_d          = '0;
                    fail_d         = 1'b0;
                    fail_pattern_d = '0;
                    fail_mask_d    = '0;
                end
            end
            WRITE: begin
                if (i_mem_ack) state_d = READ;
            end
            READ: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rdata_q != pattern) begin
                    fail_d         = 1'b1;
                    fail_pattern_d = pattern;
                    fail_mask_d    = pattern ^ rdata_q;
                    state_d        = DONE;
                end else if (idx == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx + p_NUMBER_SHIFTER'(1);
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_d  = (state_d == WRITE) || (state_d == READ);
        we_d   = (state_d == WRITE);
        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == CHECK);
        // Done rises one edge after entering DONE and drops on the accepting edge.
        done_d = (state == DONE) && !i_start;
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            o_mem_addr     <= '0;
            rdata_q        <= '0;
            o_fail         <= 1'b0;
            o_fail_pattern <= '0;
            o_fail_mask    <= '0;
            o_mem_req      <= 1'b0;
            o_mem_we       <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            o_mem_addr     <= addr_d;
            rdata_q        <= rdata_d;
            o_fail         <= fail_d;
            o_fail_pattern <= fail_pattern_d;
            o_fail_mask    <= fail_mask_d;
            o_mem_req      <= req_d;
            o_mem_we       <= we_d;
            o_busy         <= busy_d;
            o_done         <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_test_data_bus_checker.sv
// Bench for the walking-ones checker: faulty memory model, random ack delays, scoreboard of transfers.
module tb_mem_test_data_bus_checker;

    localparam int unsigned W = 8;
    localparam int unsigned A = 8;
    localparam int unsigned N = 3;
    localparam int LIMIT = 400;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [A-1:0]  i_addr;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [A-1:0]  o_mem_addr;
    logic [W-1:0]  o_mem_wdata;
    logic          i_mem_ack;
    logic [W-1:0]  i_mem_rdata;
    logic          o_busy;
    logic          o_done;
    logic          o_fail;
    logic [W-1:0]  o_fail_pattern;
    logic [W-1:0]  o_fail_mask;

    mem_test_data_bus_checker #(
        .p_WIDTH_DATA     (W),
        .p_WIDTH_ADDR     (A),
        .p_NUMBER_SHIFTER (N)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_addr         (i_addr),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_fail         (o_fail),
        .o_fail_pattern (o_fail_pattern),
        .o_fail_mask    (o_fail_mask)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic         we;
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } txn_t;

    txn_t         sb[$];
    logic [W-1:0] mem [0:255];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           fault_mode = 0;   // 0 ideal, 1 bit3 stuck at 0, 2 bits 1/2 shorted
    int           max_delay = 0;

    // Exp values from the test plan, filled by plan().
    logic         exp_fail;
    logic [W-1:0] exp_pat, exp_mask;
    int           exp_edges;
    int           edges;
    logic [2:0]   post;

    function automatic logic [W-1:0] apply_fault(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        if (fault_mode == 1) r[3] = 1'b0;
        if (fault_mode == 2 && (r[1] | r[2])) r[2:1] = 2'b11;
        return r;
    endfunction

    // Memory responder: random ack delay, deferred commit after the ack edge, hold-stability check.
    initial begin : responder
        bit           pending, commit;
        int           wait_cnt;
        txn_t         cap, exp_t;
        pending     = 0;
        commit      = 0;
        wait_cnt    = 0;
        cap         = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (commit) begin
                commit = 0;
                if (i_rst_n) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL txn_unexpected: got we=%0b addr=%h data=%h, required no transfer",
                                 cap.we, cap.addr, cap.data);
                    end else begin
                        exp_t = sb.pop_front();
                        if (cap !== exp_t) begin
                            n_fail++;
                            $display("FAIL txn_order: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                     cap.we, cap.addr, cap.data, exp_t.we, exp_t.addr, exp_t.data);
                        end
                    end
                    if (cap.we) mem[cap.addr] = cap.data;
                end
            end
            if (!i_rst_n || !o_mem_req) begin
                if (pending && i_rst_n) begin
                    n_cmp++;
                    if (o_mem_req !== 1'b1) begin
                        n_fail++;
                        $display("FAIL req_dropped: got req=%b before ack, required 1", o_mem_req);
                    end
                end
                pending     = 0;
                i_mem_ack   = i_rst_n;      // ack held high while idle must be ignored
                i_mem_rdata = W'($urandom);
            end else begin
                if (!pending) begin
                    pending  = 1;
                    wait_cnt = int'($urandom_range(max_delay, 0));
                    cap      = '{we: o_mem_we, addr: o_mem_addr, data: o_mem_wdata};
                end else begin
                    n_cmp++;
                    if ({o_mem_we, o_mem_addr, o_mem_wdata} !== {cap.we, cap.addr, cap.data}) begin
                        n_fail++;
                        $display("FAIL hold_stable: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                 o_mem_we, o_mem_addr, o_mem_wdata, cap.we, cap.addr, cap.data);
                    end
                end
                if (wait_cnt == 0) begin
                    i_mem_ack   = 1'b1;
                    pending     = 0;
                    commit      = 1;
                    i_mem_rdata = cap.we ? W'($urandom) : apply_fault(mem[cap.addr]);
                end else begin
                    wait_cnt--;
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = W'($urandom);
                end
            end
        end
    end

    // Push the expected transfer sequence and final status for the current fault mode.
    task automatic plan(input logic [A-1:0] addr);
        logic [W-1:0] p, r;
        int           last;
        exp_fail = 1'b0;
        exp_pat  = '0;
        exp_mask = '0;
        last     = W - 1;
        for (int k = 0; k < W; k++) begin
            p = W'(1) << k;
            sb.push_back('{we: 1'b1, addr: addr, data: p});
            sb.push_back('{we: 1'b0, addr: addr, data: p});
            r = apply_fault(p);
            if (r !== p) begin
                exp_fail = 1'b1;
                exp_pat  = p;
                exp_mask = p ^ r;
                last     = k;
                break;
            end
        end
        exp_edges = 3 * (last + 1) + 1;
    endtask

    task automatic run_test(input logic [A-1:0] addr, input bit poke);
        @(negedge i_clk);
        i_addr  = addr;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        post    = {o_done, o_fail, o_busy};
        edges   = 0;
        while (o_done !== 1'b1 && edges < LIMIT) begin
            @(negedge i_clk);
            edges++;
            if (poke && edges == 4) begin
                i_start = 1'b1;
                i_addr  = ~addr;
            end else if (poke && edges == 5) begin
                i_start = 1'b0;
                i_addr  = addr;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_addr  = '0;
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_fail, o_fail_pattern, o_fail_mask} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h busy=%b done=%b fail=%b pat=%h mask=%h, required all 0",
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_fail, o_fail_pattern, o_fail_mask);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if ({o_busy, o_mem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got busy=%b req=%b with ack high, required 0 0", o_busy, o_mem_req);
        end
    endtask

    task automatic test_ideal();
        fault_mode = 0;
        max_delay  = 0;
        plan(8'h5A);
        run_test(8'h5A, 1'b0);
        n_cmp++;
        if (post !== 3'b001) begin
            n_fail++; $display("FAIL ideal_post_start: got done/fail/busy=%b, required 001", post);
        end
        n_cmp++;
        if (edges !== exp_edges) begin
            n_fail++; $display("FAIL ideal_latency: got %0d edges, required %0d", edges, exp_edges);
        end
        n_cmp++;
        if ({o_done, o_fail, o_fail_pattern, o_fail_mask, o_busy} !== {1'b1, exp_fail, exp_pat, exp_mask, 1'b0}) begin
            n_fail++; $display("FAIL ideal_status: got done=%b fail=%b pat=%h mask=%h busy=%b, required 1 %b %h %h 0",
                               o_done, o_fail, o_fail_pattern, o_fail_mask, o_busy, exp_fail, exp_pat, exp_mask);
        end
        n_cmp++;
        if ({sb.size() == 0, o_mem_addr} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL ideal_txn_count: got %0d left addr=%h, required 0 left addr=5a", sb.size(), o_mem_addr);
        end
    endtask

    task automatic test_stuck_bit3();
        fault_mode = 1;
        max_delay  = 0;
        plan(8'h33);
        run_test(8'h33, 1'b0);
        n_cmp++;
        if (edges !== exp_edges) begin
            n_fail++; $display("FAIL stuck_latency: got %0d edges, required %0d", edges, exp_edges);
        end
        n_cmp++;
        if ({o_done, o_fail, o_fail_pattern, o_fail_mask} !== {1'b1, 1'b1, 8'h08, 8'h08}) begin
            n_fail++; $display("FAIL stuck_status: got done=%b fail=%b pat=%h mask=%h, required 1 1 08 08",
                               o_done, o_fail, o_fail_pattern, o_fail_mask);
        end
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({sb.size() == 0, o_mem_req} !== 2'b10) begin
            n_fail++; $display("FAIL stuck_no_more_txn: got %0d left req=%b, required 0 left req=0", sb.size(), o_mem_req);
        end
    endtask

    task automatic test_short_bits12();
        fault_mode = 2;
        max_delay  = 0;
        plan(8'hA0);
        run_test(8'hA0, 1'b0);
        n_cmp++;
        if (edges !== exp_edges) begin
            n_fail++; $display("FAIL short_latency: got %0d edges, required %0d", edges, exp_edges);
        end
        n_cmp++;
        if ({o_done, o_fail, o_fail_pattern, o_fail_mask, sb.size() == 0} !== {1'b1, 1'b1, 8'h02, 8'h04, 1'b1}) begin
            n_fail++; $display("FAIL short_status: got done=%b fail=%b pat=%h mask=%h left=%0d, required 1 1 02 04 0",
                               o_done, o_fail, o_fail_pattern, o_fail_mask, sb.size());
        end
    endtask

    task automatic test_random_ack();
        fault_mode = 0;
        max_delay  = 5;
        plan(8'h96);
        run_test(8'h96, 1'b0);
        n_cmp++;
        if (edges >= LIMIT) begin
            n_fail++; $display("FAIL random_timeout: got %0d edges without done, required fewer than %0d", edges, LIMIT);
        end
        n_cmp++;
        if ({o_done, o_fail, o_fail_pattern, o_fail_mask, sb.size() == 0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL random_status: got done=%b fail=%b pat=%h mask=%h left=%0d, required 1 0 00 00 0",
                               o_done, o_fail, o_fail_pattern, o_fail_mask, sb.size());
        end
        max_delay = 0;
    endtask

    task automatic test_busy_start();
        fault_mode = 1;
        plan(8'hC3);
        run_test(8'hC3, 1'b1);
        n_cmp++;
        if ({edges, o_mem_addr, o_fail, o_fail_pattern} !== {exp_edges, 8'hC3, 1'b1, 8'h08}) begin
            n_fail++; $display("FAIL busy_start_ignored: got edges=%0d addr=%h fail=%b pat=%h, required %0d c3 1 08",
                               edges, o_mem_addr, o_fail, o_fail_pattern, exp_edges);
        end
        fault_mode = 0;
        plan(8'h3C);
        run_test(8'h3C, 1'b0);
        n_cmp++;
        if (post !== 3'b001) begin
            n_fail++; $display("FAIL restart_clears: got done/fail/busy=%b, required 001", post);
        end
        n_cmp++;
        if ({edges, o_fail, o_fail_pattern, o_fail_mask, sb.size() == 0} !== {exp_edges, 1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL restart_run: got edges=%0d fail=%b pat=%h mask=%h left=%0d, required %0d 0 00 00 0",
                               edges, o_fail, o_fail_pattern, o_fail_mask, sb.size(), exp_edges);
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        fault_mode = 0;
        max_delay  = 0;
        plan(8'h77);
        @(negedge i_clk);
        i_addr  = 8'h77;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge i_clk);
            hit = (o_mem_req === 1'b1 && o_mem_we === 1'b0 && o_mem_wdata === 8'h04);
        end
        n_cmp++;
        if (!hit) begin
            n_fail++; $display("FAIL rst_read04_seen: got no read of 04, required one");
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_fail, o_fail_pattern, o_fail_mask} !== 37'd0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b we=%b addr=%h wdata=%h busy=%b done=%b fail=%b, required all 0",
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_fail);
        end
        repeat (2) @(negedge i_clk);
        sb.delete();
        i_rst_n = 1'b1;
        plan(8'h77);
        run_test(8'h77, 1'b0);
        n_cmp++;
        if ({edges, o_done, o_fail, sb.size() == 0} !== {exp_edges, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL post_reset_run: got edges=%0d done=%b fail=%b left=%0d, required %0d 1 0 0",
                               edges, o_done, o_fail, sb.size(), exp_edges);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_ideal();
        test_stuck_bit3();
        test_short_bits12();
        test_random_ack();
        test_busy_start();
        test_async_reset();
        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_test_data_bus_checker.md
Name: mem_test_data_bus_checker

Overview:
Sequential walking-ones data bus test controller. For each bit position it writes a one-hot pattern to a single test address, reads the word back and compares it with the expected pattern. It stops at the first mismatch, or passes after all p_WIDTH_DATA patterns. It sits between the memTest top level and the memory under test, and is the consumer/checker for the walking patterns that the shifter block generates.

Parameters:
- p_WIDTH_DATA, 8, data bus width under test.
- p_WIDTH_ADDR, 8, memory address width.
- p_NUMBER_SHIFTER, 3, bit-index counter width; must satisfy 2**p_NUMBER_SHIFTER >= p_WIDTH_DATA.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE or DONE.
- i_addr  input  p_WIDTH_ADDR  test address; captured on accepted start.
- o_mem_req  output  1  memory transfer request.
- o_mem_we  output  1  1 = write, 0 = read; valid while o_mem_req=1.
- o_mem_addr  output  p_WIDTH_ADDR  captured test address.
- o_mem_wdata  output  p_WIDTH_DATA  current walking pattern.
- i_mem_ack  input  1  transfer complete in the cycle where o_mem_req=1 and i_mem_ack=1.
- i_mem_rdata  input  p_WIDTH_DATA  read data; valid only in the read-ack cycle.
- o_busy  output  1  test in progress.
- o_done  output  1  test finished; held until the next accepted start.
- o_fail  output  1  mismatch detected; valid while o_done=1.
- o_fail_pattern  output  p_WIDTH_DATA  expected pattern at the first failure.
- o_fail_mask  output  p_WIDTH_DATA  expected XOR read at the first failure.

Behaviour:
- Reset value of every output and register is 0: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_done, o_fail, o_fail_pattern, o_fail_mask, bit index. The state resets to IDLE.
- Reset asserted mid-operation aborts immediately. No memory transfer completes after reset assertion.
- Every output is driven from registers or from a decode of the state register; there are no combinational paths from inputs to outputs.
- Pattern = 1 << idx, with width p_WIDTH_DATA. idx runs from 0 to p_WIDTH_DATA-1.
- FSM states:
  - IDLE: i_start=1 captures i_addr, sets idx=0, clears o_fail, o_fail_pattern and o_fail_mask, then goes to WRITE.
  - WRITE: o_mem_req=1, o_mem_we=1, o_busy=1. Holds until i_mem_ack=1, then goes to READ.
  - READ: o_mem_req=1, o_mem_we=0. On i_mem_ack=1, registers i_mem_rdata and goes to CHECK.
  - CHECK: o_mem_req=0.
    - Mismatch: o_fail=1, o_fail_pattern=pattern, o_fail_mask=pattern^rdata, go to DONE.
    - Match with idx=p_WIDTH_DATA-1: go to DONE with o_fail=0.
    - Match otherwise: idx++ and go to WRITE.
  - DONE: o_done=1, o_busy=0. i_start=1 behaves as in IDLE: clears o_done and status, then goes to WRITE.
- Handshake:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata stay stable from request assertion until the ack cycle.
  - An ack seen while o_mem_req=0 is ignored.
  - No wait-cycle limit; the block waits indefinitely for ack.
- i_start is ignored while o_busy=1.
- Latency with i_mem_ack tied high: 3 cycles per pattern. o_done rises 3*p_WIDTH_DATA+1 clock edges after the start-sampling edge (25 for the default width). Early failure at idx k gives o_done 3*(k+1)+1 edges after start.
- o_mem_addr stays constant for the entire test.

Decomposition:
- Shared package memtest_pkg:
  - State enum typedef: IDLE, WRITE, READ, CHECK, DONE.
  - Pattern-count constant derived from p_WIDTH_DATA.
- One sub-module: the existing shifter, instantiated with i_value=1, i_RL=1 and i_shifter=idx, generating o_mem_wdata. Its o_zero output is unused.

Test Plan:
- Ideal memory, ack tied high, W=8, i_addr=8'h5A, start pulse → wdata sequence 01,02,04,…,80, all at addr 5A. o_done=1, o_fail=0, 25 edges after start.
- Data bit 3 stuck at 0 → fail at pattern 8'h08, rdata 00. o_fail=1, o_fail_pattern=08, o_fail_mask=08, no write of 8'h10 issued.
- Bits 1 and 2 shorted (rdata = wdata OR'd across bits 1 and 2) → fail at 02, o_fail_mask=04.
- Random ack delays of 0–5 cycles → req, we, addr and wdata stable until ack. Same pass result, one write and one read per pattern.
- i_start pulsed while busy, then again in DONE → first pulse ignored. Second pulse clears o_done and o_fail and restarts at pattern 01.
- i_rst_n low during READ of pattern 04 → all outputs 0 asynchronously, state IDLE. The next start runs a full, clean test.
